// File: rtl/sbox_share_ctrl.sv
// Shares one byte-serial AES S-box between the round datapath (D, full state)
// and the key expansion (K, one word) with round-robin arbitration.
module sbox_share_ctrl #(
   parameter int DATA_BYTES = 16,
   parameter int KEY_BYTES  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    d_req_valid,
   output logic                    d_req_ready,
   input  logic [8*DATA_BYTES-1:0] d_in,
   output logic                    d_out_valid,
   input  logic                    d_out_ready,
   output logic [8*DATA_BYTES-1:0] d_out,
   input  logic                    k_req_valid,
   output logic                    k_req_ready,
   input  logic [8*KEY_BYTES-1:0]  k_in,
   output logic                    k_out_valid,
   input  logic                    k_out_ready,
   output logic [8*KEY_BYTES-1:0]  k_out,
   output logic                    busy
);

   localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [IDX_W-1:0] D_LAST = IDX_W'(DATA_BYTES - 1);
   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(KEY_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) begin
            p = p ^ x;
         end else begin
            p = p;
         end
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero naturally.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x14  = gf_mul(x12, x2);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      return gf_mul(x240, x14);
   endfunction

   function automatic logic [7:0] sub_byte(input logic [7:0] a);
      logic [7:0] b;
      b = gf_inv(a);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   state_t                          state_r, state_n_s;
   logic [DATA_BYTES-1:0][7:0]      op_buf_r, op_buf_n_s;
   logic [DATA_BYTES-1:0][7:0]      res_r, res_n_s;
   logic [IDX_W-1:0]                idx_r, idx_n_s;
   logic                            served_k_r, served_k_n_s;
   logic                            prio_k_r, prio_k_n_s;
   logic                            d_out_valid_r, k_out_valid_r, busy_r;
   logic                            k_acc_s, d_acc_s, out_ready_s;
   logic [IDX_W-1:0]                last_idx_s;
   logic [7:0]                      sbox_out_s;

   assign k_req_ready = (state_r == IDLE) & (~d_req_valid | prio_k_r);
   assign d_req_ready = (state_r == IDLE) & (~k_req_valid | ~prio_k_r);
   assign k_acc_s     = k_req_valid & k_req_ready;
   assign d_acc_s     = d_req_valid & d_req_ready;
   assign last_idx_s  = served_k_r ? K_LAST : D_LAST;
   assign out_ready_s = served_k_r ? k_out_ready : d_out_ready;
   assign sbox_out_s  = sub_byte(op_buf_r[idx_r]);

   assign d_out       = res_r;
   assign k_out       = res_r[KEY_BYTES-1:0];
   assign d_out_valid = d_out_valid_r;
   assign k_out_valid = k_out_valid_r;
   assign busy        = busy_r;

   // Next-state, datapath and arbitration priority update.
   always_comb begin
      state_n_s    = state_r;
      op_buf_n_s   = op_buf_r;
      res_n_s      = res_r;
      idx_n_s      = idx_r;
      served_k_n_s = served_k_r;
      prio_k_n_s   = prio_k_r;
      case (state_r)
         IDLE: begin
            if (k_acc_s) begin
               state_n_s                   = RUN;
               op_buf_n_s                  = {DATA_BYTES{8'h00}};
               op_buf_n_s[KEY_BYTES-1:0]   = k_in;
               served_k_n_s                = 1'b1;
               idx_n_s                     = {IDX_W{1'b0}};
            end else if (d_acc_s) begin
               state_n_s    = RUN;
               op_buf_n_s   = d_in;
               served_k_n_s = 1'b0;
               idx_n_s      = {IDX_W{1'b0}};
            end else begin
               state_n_s = IDLE;
            end
         end
         RUN: begin
            res_n_s[idx_r] = sbox_out_s;
            idx_n_s        = idx_r + IDX_W'(1);
            if (idx_r == last_idx_s) begin
               state_n_s = HOLD;
            end else begin
               state_n_s = RUN;
            end
         end
         HOLD: begin
            // Hand the next tie to whichever requester was not just served.
            if (out_ready_s) begin
               state_n_s  = IDLE;
               prio_k_n_s = ~served_k_r;
            end else begin
               state_n_s = HOLD;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered output flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         op_buf_r      <= {DATA_BYTES{8'h00}};
         res_r         <= {DATA_BYTES{8'h00}};
         idx_r         <= {IDX_W{1'b0}};
         served_k_r    <= 1'b0;
         prio_k_r      <= 1'b1;
         d_out_valid_r <= 1'b0;
         k_out_valid_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_n_s;
         op_buf_r      <= op_buf_n_s;
         res_r         <= res_n_s;
         idx_r         <= idx_n_s;
         served_k_r    <= served_k_n_s;
         prio_k_r      <= prio_k_n_s;
         d_out_valid_r <= (state_n_s == HOLD) & ~served_k_n_s;
         k_out_valid_r <= (state_n_s == HOLD) & served_k_n_s;
         busy_r        <= (state_n_s != IDLE);
      end
   end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Directed bench for sbox_share_ctrl: vector table of single jobs plus
// hand-written tie, back-pressure and mid-job reset sequences.
module tb_sbox_share_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         d_req_valid, d_req_ready, d_out_valid, d_out_ready;
   logic [127:0] d_in, d_out;
   logic         k_req_valid, k_req_ready, k_out_valid, k_out_ready;
   logic [31:0]  k_in, k_out;
   logic         busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      bit           is_k;
      logic [127:0] din;
      logic [31:0]  kin;
      logic [127:0] exp;
   } vec_t;

   vec_t vecs[8];

   localparam logic [127:0] D_VEC = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] D_EXP = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [31:0]  K_VEC = 32'hcf4f3c09;
   localparam logic [31:0]  K_EXP = 32'h8a84eb01;

   always #5 clk = ~clk;

   sbox_share_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_in(d_in),
      .d_out_valid(d_out_valid), .d_out_ready(d_out_ready), .d_out(d_out),
      .k_req_valid(k_req_valid), .k_req_ready(k_req_ready), .k_in(k_in),
      .k_out_valid(k_out_valid), .k_out_ready(k_out_ready), .k_out(k_out),
      .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_reset();
      rst_n       = 1'b0;
      d_req_valid = 1'b0;
      k_req_valid = 1'b0;
      d_out_ready = 1'b1;
      k_out_ready = 1'b1;
      d_in        = 128'h0;
      k_in        = 32'h0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Waits for the selected out_valid; returns edges elapsed (bounded).
   task automatic wait_valid(input bit is_k, output int cycles);
      cycles = 0;
      while (((is_k ? k_out_valid : d_out_valid) !== 1'b1) && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   task automatic run_job(input int n, input vec_t v);
      int  cyc;
      bit  other_seen;
      if (v.is_k) begin
         k_in = v.kin; k_req_valid = 1'b1;
      end else begin
         d_in = v.din; d_req_valid = 1'b1;
      end
      #1;
      check($sformatf("vec%0d ready", n), v.is_k ? k_req_ready : d_req_ready, 128'd1);
      tick();
      k_req_valid = 1'b0;
      d_req_valid = 1'b0;
      other_seen  = 1'b0;
      cyc = 0;
      while (((v.is_k ? k_out_valid : d_out_valid) !== 1'b1) && cyc < 40) begin
         if ((v.is_k ? d_out_valid : k_out_valid) !== 1'b0) other_seen = 1'b1;
         tick();
         cyc++;
      end
      check($sformatf("vec%0d latency", n), 128'(cyc), v.is_k ? 128'd4 : 128'd16);
      check($sformatf("vec%0d data", n), v.is_k ? 128'(k_out) : d_out,
            v.is_k ? {96'h0, v.exp[31:0]} : v.exp);
      check($sformatf("vec%0d other_valid", n), 128'(other_seen), 128'd0);
      tick();
      check($sformatf("vec%0d idle", n), 128'(busy), 128'd0);
   endtask

   initial begin
      int cyc;
      vecs[0] = '{1'b0, D_VEC, 32'h0, D_EXP};
      vecs[1] = '{1'b0, {16{8'h00}}, 32'h0, {16{8'h63}}};
      vecs[2] = '{1'b0, {16{8'hff}}, 32'h0, {16{8'h16}}};
      vecs[3] = '{1'b0, {4{32'hff530100}}, 32'h0, {4{32'h16ed7c63}}};
      vecs[4] = '{1'b0, {4{32'h00ff5301}}, 32'h0, {4{32'h6316ed7c}}};
      vecs[5] = '{1'b0, {4{32'h0100ff53}}, 32'h0, {4{32'h7c6316ed}}};
      vecs[6] = '{1'b0, {4{32'h530100ff}}, 32'h0, {4{32'hed7c6316}}};
      vecs[7] = '{1'b1, 128'h0, 32'hff530100, {96'h0, 32'h16ed7c63}};

      // Reset state and lone K job with cycle-by-cycle busy / valid profile.
      apply_reset();
      check("rst busy", 128'(busy), 128'd0);
      check("rst d_out_valid", 128'(d_out_valid), 128'd0);
      check("rst k_out_valid", 128'(k_out_valid), 128'd0);
      check("rst d_out", d_out, 128'h0);
      k_in = K_VEC; k_req_valid = 1'b1; #1;
      check("k1 ready", 128'(k_req_ready), 128'd1);
      tick();
      k_req_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("k1 busy@%0d", i), 128'(busy), (i <= 4) ? 128'd1 : 128'd0);
         check($sformatf("k1 kvalid@%0d", i), 128'(k_out_valid), (i == 4) ? 128'd1 : 128'd0);
         if (i == 4) check("k1 data", 128'(k_out), 128'(K_EXP));
         tick();
      end

      // Vector table: D and K single jobs.
      for (int i = 0; i < 8; i++) run_job(i, vecs[i]);

      // Tie after reset: K first, D next, second tie to K again.
      apply_reset();
      d_in = D_VEC; k_in = K_VEC; d_req_valid = 1'b1; k_req_valid = 1'b1; #1;
      check("tie1 k_ready", 128'(k_req_ready), 128'd1);
      check("tie1 d_ready", 128'(d_req_ready), 128'd0);
      tick();
      k_req_valid = 1'b0;
      check("tie1 d_ready run", 128'(d_req_ready), 128'd0);
      wait_valid(1'b1, cyc);
      check("tie1 k_lat", 128'(cyc), 128'd4);
      check("tie1 k_data", 128'(k_out), 128'(K_EXP));
      tick();
      check("tie1 d_ready after pop", 128'(d_req_ready), 128'd1);
      tick();
      d_req_valid = 1'b0;
      wait_valid(1'b0, cyc);
      check("tie1 d_lat", 128'(cyc), 128'd16);
      check("tie1 d_data", d_out, D_EXP);
      tick();
      d_req_valid = 1'b1; k_req_valid = 1'b1; #1;
      check("tie2 k_ready", 128'(k_req_ready), 128'd1);
      check("tie2 d_ready", 128'(d_req_ready), 128'd0);
      tick();
      d_req_valid = 1'b0; k_req_valid = 1'b0;
      wait_valid(1'b1, cyc);
      check("tie2 k_data", 128'(k_out), 128'(K_EXP));
      tick();

      // Back-pressure: hold D result for 10 cycles with requests pending.
      d_in = D_VEC; d_out_ready = 1'b0; d_req_valid = 1'b1;
      tick();
      d_req_valid = 1'b0;
      wait_valid(1'b0, cyc);
      check("hold lat", 128'(cyc), 128'd16);
      d_req_valid = 1'b1; k_req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check($sformatf("hold valid@%0d", i), 128'(d_out_valid), 128'd1);
         check($sformatf("hold data@%0d", i), d_out, D_EXP);
         check($sformatf("hold rdy@%0d", i), {126'h0, d_req_ready, k_req_ready}, 128'd0);
         tick();
      end
      d_req_valid = 1'b0; k_req_valid = 1'b0; d_out_ready = 1'b1;
      tick();
      check("hold popped", {126'h0, busy, d_out_valid}, 128'd0);

      // Reset in the middle of a D job (idx = 7).
      d_in = D_VEC; d_req_valid = 1'b1;
      tick();
      d_req_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("mid busy before rst", 128'(busy), 128'd1);
      rst_n = 1'b0; #1;
      check("mid rst busy", 128'(busy), 128'd0);
      check("mid rst d_out", d_out, 128'h0);
      check("mid rst valids", {126'h0, d_out_valid, k_out_valid}, 128'd0);
      tick();
      rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         if (d_out_valid !== 1'b0 || k_out_valid !== 1'b0 || busy !== 1'b0) cyc++;
         tick();
      end
      check("mid post-rst quiet", 128'(cyc), 128'd0);
      d_req_valid = 1'b1; k_req_valid = 1'b1; #1;
      check("mid post-rst prio_k", {126'h0, k_req_ready, d_req_ready}, 128'd2);
      d_req_valid = 1'b0; k_req_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
